btn_debounce_ce: RTL

Debounces one raw, asynchronous push-button or switch input. Produces a clean level plus single-cycle rise/fall strobes. Sits directly upstream of the lab's synchronous-reset D flip-flop with clock enable: `btn_level` drives its `D`, and `btn_rise` drives its `ce`. This gives a press-to-capture path with no bounce or metastability.

---
 rtl/btn_debounce_ce_pkg.sv | 10 +
 rtl/synch_2ff.sv | 24 ++
 rtl/btn_debounce_ce.sv | 130 +++++++++++++
 3 files changed

// File: rtl/btn_debounce_ce_pkg.sv
// Shared debounce settings for the lab: production and simulation stability counts
// with the counter widths that fit them.
package btn_debounce_ce_pkg;

   localparam int unsigned SYN_STABLE_COUNT = 1000000;
   localparam int unsigned SYN_CNT_WIDTH    = 20;
   localparam int unsigned SIM_STABLE_COUNT = 4;
   localparam int unsigned SIM_CNT_WIDTH    = 3;

endpackage : btn_debounce_ce_pkg

// File: rtl/synch_2ff.sv
// Two-flop synchronizer for asynchronous inputs; synchronous active-high reset.
module synch_2ff (
   input  logic Clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule : synch_2ff

// File: rtl/btn_debounce_ce.sv
// Button debouncer: synchronizes btn_in, accepts a new level after STABLE_COUNT
// consecutive differing samples, and emits registered one-cycle rise/fall strobes.
module btn_debounce_ce
   import btn_debounce_ce_pkg::*;
#(
   parameter int unsigned CNT_WIDTH    = SYN_CNT_WIDTH,
   parameter int unsigned STABLE_COUNT = SYN_STABLE_COUNT
) (
   input  logic Clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_level,
   output logic btn_rise,
   output logic btn_fall
);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);
   localparam bit                   BYPASS   = (STABLE_COUNT == 1);

   logic                 w_s;
   state_t               r_state, w_state_nxt;
   logic [CNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
   logic                 r_level, w_level_nxt;
   logic                 r_rise, w_rise_nxt;
   logic                 r_fall, w_fall_nxt;

   synch_2ff u_sync (
      .Clk  (Clk),
      .reset(reset),
      .d    (btn_in),
      .q    (w_s)
   );

   always_ff @(posedge Clk) begin
      if (reset) begin
         r_state <= IDLE_LOW;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   // A WAIT state falls back on any sample matching the current level, so only an
   // unbroken run of STABLE_COUNT differing samples is accepted.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_level_nxt = r_level;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      unique case (r_state)
         IDLE_LOW: begin
            w_cnt_nxt = '0;
            if (w_s) begin
               if (BYPASS) begin
                  w_state_nxt = IDLE_HIGH;
                  w_level_nxt = 1'b1;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_state_nxt = WAIT_HIGH;
                  w_cnt_nxt   = CNT_WIDTH'(1);
               end
            end
         end
         WAIT_HIGH: begin
            if (!w_s) begin
               w_state_nxt = IDLE_LOW;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE_HIGH;
               w_cnt_nxt   = '0;
               w_level_nxt = 1'b1;
               w_rise_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            end
         end
         IDLE_HIGH: begin
            w_cnt_nxt = '0;
            if (!w_s) begin
               if (BYPASS) begin
                  w_state_nxt = IDLE_LOW;
                  w_level_nxt = 1'b0;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_state_nxt = WAIT_LOW;
                  w_cnt_nxt   = CNT_WIDTH'(1);
               end
            end
         end
         WAIT_LOW: begin
            if (w_s) begin
               w_state_nxt = IDLE_HIGH;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_state_nxt = IDLE_LOW;
               w_cnt_nxt   = '0;
               w_level_nxt = 1'b0;
               w_fall_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_WIDTH'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
         end
      endcase
   end

   assign btn_level = r_level;
   assign btn_rise  = r_rise;
   assign btn_fall  = r_fall;

endmodule : btn_debounce_ce
